// File: rtl/game_round_ctrl.sv
// game_round_ctrl: round sequencer for the falling-object catch game.
// Runs the IDLE/COUNTDOWN/PLAY/PAUSE/OVER state machine and generates the
// level-dependent drop tick. It also keeps score, miss count and level.
// Optional feature macro: GAME_HIGH_SCORE_EN adds a best-score register that
// is updated on entry to OVER. Without the macro, high_score is tied to 0.
module game_round_ctrl #(
    parameter int TICK_BASE        = 1048576,
    parameter int COUNTDOWN_CYCLES = 3145728,
    parameter int LEVEL_STEP       = 5,
    parameter int MAX_MISS         = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_btn,
    input  logic       pause_btn,
    input  logic       hit,
    input  logic       miss_in,
    output logic       drop_tick,
    output logic       drop_rst,
    output logic       play_en,
    output logic [2:0] state,
    output logic [7:0] score,
    output logic [3:0] miss,
    output logic [2:0] level,
    output logic [7:0] high_score,
    output logic       game_over
);

    localparam int TW = $clog2(TICK_BASE + 1);
    localparam int CW = $clog2(COUNTDOWN_CYCLES + 1);
    localparam int HW = $clog2(LEVEL_STEP + 1);
    localparam logic [TW-1:0] TICK_BASE_W = TW'(TICK_BASE);
    localparam logic [CW-1:0] CD_LAST     = CW'(COUNTDOWN_CYCLES - 1);
    localparam logic [HW-1:0] HITS_LAST   = HW'(LEVEL_STEP - 1);
    localparam logic [3:0]    MISS_LIMIT  = 4'(MAX_MISS);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_COUNTDOWN = 3'd1,
        ST_PLAY      = 3'd2,
        ST_PAUSE     = 3'd3,
        ST_OVER      = 3'd4
    } state_t;

    // Score saturates at 255 rather than wrapping.
    function automatic logic [7:0] sat_score_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Level saturates at 4, the fastest drop rate.
    function automatic logic [2:0] sat_level_inc(input logic [2:0] v);
        return (v >= 3'd4) ? 3'd4 : v + 3'd1;
    endfunction

    state_t        state_q, state_d;
    logic          start_btn_q, start_btn_d;
    logic          pause_btn_q, pause_btn_d;
    logic          start_rise_q, start_rise_d;
    logic          pause_rise_q, pause_rise_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [CW-1:0] cd_cnt_q, cd_cnt_d;
    logic [HW-1:0] hits_lvl_q, hits_lvl_d;
    logic [7:0]    score_q, score_d;
    logic [3:0]    miss_q, miss_d;
    logic [2:0]    level_q, level_d;
    logic          drop_tick_q, drop_tick_d;
    logic          drop_rst_q, drop_rst_d;
    logic          play_en_q, play_en_d;
    logic          game_over_q, game_over_d;
    logic [TW-1:0] tick_last;
`ifdef GAME_HIGH_SCORE_EN
    logic [7:0]    high_score_q, high_score_d;
`endif

    // Next-state and next-output computation for the whole round sequencer.
    always_comb begin
        state_d      = state_q;
        start_btn_d  = start_btn;
        pause_btn_d  = pause_btn;
        start_rise_d = start_btn & ~start_btn_q;
        pause_rise_d = pause_btn & ~pause_btn_q;
        tick_cnt_d   = tick_cnt_q;
        cd_cnt_d     = cd_cnt_q;
        hits_lvl_d   = hits_lvl_q;
        score_d      = score_q;
        miss_d       = miss_q;
        level_d      = level_q;
        drop_tick_d  = 1'b0;
        drop_rst_d   = 1'b0;
        // Period limit follows the registered level, so a level-up mid-period
        // takes effect on the next compare.
        tick_last    = (TICK_BASE_W >> level_q) - TW'(1);

        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start_rise_q) begin
                    score_d    = 8'd0;
                    miss_d     = 4'd0;
                    level_d    = 3'd0;
                    hits_lvl_d = '0;
                    tick_cnt_d = '0;
                    cd_cnt_d   = '0;
                    drop_rst_d = 1'b1;
                    state_d    = ST_COUNTDOWN;
                end
            end
            ST_COUNTDOWN: begin
                if (cd_cnt_q == CD_LAST) begin
                    tick_cnt_d = '0;
                    state_d    = ST_PLAY;
                end else begin
                    cd_cnt_d = cd_cnt_q + CW'(1);
                end
            end
            ST_PLAY: begin
                if (tick_cnt_q >= tick_last) begin
                    drop_tick_d = 1'b1;
                    tick_cnt_d  = '0;
                end else begin
                    tick_cnt_d = tick_cnt_q + TW'(1);
                end
                if (hit) begin
                    score_d = sat_score_inc(score_q);
                    if (hits_lvl_q == HITS_LAST) begin
                        hits_lvl_d = '0;
                        level_d    = sat_level_inc(level_q);
                    end else begin
                        hits_lvl_d = hits_lvl_q + HW'(1);
                    end
                end
                if (miss_in) begin
                    miss_d = miss_q + 4'd1;
                end
                // A terminating miss takes priority over a pause request.
                if (miss_in && (miss_d == MISS_LIMIT)) begin
                    state_d = ST_OVER;
                end else if (pause_rise_q) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (pause_rise_q) begin
                    state_d = ST_PLAY;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        play_en_d   = (state_d == ST_PLAY);
        game_over_d = (state_d == ST_OVER);

`ifdef GAME_HIGH_SCORE_EN
        high_score_d = high_score_q;
        if ((state_d == ST_OVER) && (state_q != ST_OVER) && (score_d > high_score_q)) begin
            high_score_d = score_d;
        end
`endif
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            start_btn_q  <= 1'b0;
            pause_btn_q  <= 1'b0;
            start_rise_q <= 1'b0;
            pause_rise_q <= 1'b0;
            tick_cnt_q   <= '0;
            cd_cnt_q     <= '0;
            hits_lvl_q   <= '0;
            score_q      <= 8'd0;
            miss_q       <= 4'd0;
            level_q      <= 3'd0;
            drop_tick_q  <= 1'b0;
            drop_rst_q   <= 1'b0;
            play_en_q    <= 1'b0;
            game_over_q  <= 1'b0;
`ifdef GAME_HIGH_SCORE_EN
            high_score_q <= 8'd0;
`endif
        end else begin
            state_q      <= state_d;
            start_btn_q  <= start_btn_d;
            pause_btn_q  <= pause_btn_d;
            start_rise_q <= start_rise_d;
            pause_rise_q <= pause_rise_d;
            tick_cnt_q   <= tick_cnt_d;
            cd_cnt_q     <= cd_cnt_d;
            hits_lvl_q   <= hits_lvl_d;
            score_q      <= score_d;
            miss_q       <= miss_d;
            level_q      <= level_d;
            drop_tick_q  <= drop_tick_d;
            drop_rst_q   <= drop_rst_d;
            play_en_q    <= play_en_d;
            game_over_q  <= game_over_d;
`ifdef GAME_HIGH_SCORE_EN
            high_score_q <= high_score_d;
`endif
        end
    end

    assign state     = state_q;
    assign score     = score_q;
    assign miss      = miss_q;
    assign level     = level_q;
    assign drop_tick = drop_tick_q;
    assign drop_rst  = drop_rst_q;
    assign play_en   = play_en_q;
    assign game_over = game_over_q;
`ifdef GAME_HIGH_SCORE_EN
    assign high_score = high_score_q;
`else
    assign high_score = 8'd0;
`endif

endmodule

// File: tb/tb_game_round_ctrl.sv
// Testbench for game_round_ctrl: directed round scenarios plus randomized
// button/hit/miss traffic, compared every cycle against a behavioural model
// of the round rules.
module tb_game_round_ctrl;

    localparam int TB_TICK = 16;
    localparam int TB_CD   = 8;
    localparam int TB_LS   = 2;
    localparam int TB_MM   = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_btn, pause_btn, hit, miss_in;
    logic       drop_tick, drop_rst, play_en, game_over;
    logic [2:0] state;
    logic [7:0] score;
    logic [3:0] miss;
    logic [2:0] level;
    logic [7:0] high_score;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Reference model state: mode 0..4, hits since round start, misses.
    int m_mode, m_hits, m_misses, m_phase, m_cd_left, m_hs;
    bit m_start_prev, m_start_pend, m_pause_prev, m_pause_pend;
    bit exp_tick, exp_drst;

    game_round_ctrl #(
        .TICK_BASE(TB_TICK),
        .COUNTDOWN_CYCLES(TB_CD),
        .LEVEL_STEP(TB_LS),
        .MAX_MISS(TB_MM)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start_btn(start_btn),
        .pause_btn(pause_btn),
        .hit(hit),
        .miss_in(miss_in),
        .drop_tick(drop_tick),
        .drop_rst(drop_rst),
        .play_en(play_en),
        .state(state),
        .score(score),
        .miss(miss),
        .level(level),
        .high_score(high_score),
        .game_over(game_over)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int m_level();
        int l;
        l = m_hits / TB_LS;
        return (l > 4) ? 4 : l;
    endfunction

    function automatic int m_score();
        return (m_hits > 255) ? 255 : m_hits;
    endfunction

    // Apply the round rules for one clock edge, using the inputs present at it.
    task automatic model_step();
        bit s_act, p_act;
        int per;
        exp_tick = 0;
        exp_drst = 0;
        if (rst) begin
            m_mode = 0; m_hits = 0; m_misses = 0; m_hs = 0;
            m_start_prev = 0; m_start_pend = 0;
            m_pause_prev = 0; m_pause_pend = 0;
            return;
        end
        // A button edge seen at one edge acts at the following edge.
        s_act = m_start_pend;
        p_act = m_pause_pend;
        m_start_pend = start_btn && !m_start_prev;
        m_start_prev = start_btn;
        m_pause_pend = pause_btn && !m_pause_prev;
        m_pause_prev = pause_btn;
        case (m_mode)
            0, 4: begin
                if (s_act) begin
                    m_hits = 0; m_misses = 0;
                    exp_drst = 1;
                    m_mode = 1;
                    m_cd_left = TB_CD;
                end
            end
            1: begin
                m_cd_left--;
                if (m_cd_left == 0) begin
                    m_mode = 2;
                    m_phase = 0;
                end
            end
            2: begin
                per = TB_TICK >> m_level();
                if (m_phase >= per - 1) begin
                    exp_tick = 1;
                    m_phase = 0;
                end else begin
                    m_phase++;
                end
                if (hit) m_hits++;
                if (miss_in) m_misses++;
                if (miss_in && m_misses == TB_MM) begin
                    m_mode = 4;
`ifdef GAME_HIGH_SCORE_EN
                    if (m_score() > m_hs) m_hs = m_score();
`endif
                end else if (p_act) begin
                    m_mode = 3;
                end
            end
            3: if (p_act) m_mode = 2;
            default: m_mode = 0;
        endcase
    endtask

    task automatic compare_all();
        check("state", state, m_mode);
        check("drop_tick", drop_tick, exp_tick);
        check("drop_rst", drop_rst, exp_drst);
        check("play_en", play_en, m_mode == 2);
        check("game_over", game_over, m_mode == 4);
        check("score", score, m_score());
        check("miss", miss, m_misses);
        check("level", level, m_level());
        check("high_score", high_score, m_hs);
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_step();
            #1;
            cyc++;
            compare_all();
        end
    endtask

    task automatic press_start();
        start_btn = 1'b1; step(2);
        start_btn = 1'b0; step(1);
    endtask

    task automatic press_pause();
        pause_btn = 1'b1; step(2);
        pause_btn = 1'b0; step(1);
    endtask

    task automatic pulse_hit();
        hit = 1'b1; step(1); hit = 1'b0; step(1);
    endtask

    task automatic pulse_miss();
        miss_in = 1'b1; step(1); miss_in = 1'b0; step(1);
    endtask

    initial begin
        rst = 1'b1; start_btn = 1'b0; pause_btn = 1'b0; hit = 1'b0; miss_in = 1'b0;
        m_mode = 0; m_hits = 0; m_misses = 0; m_phase = 0; m_cd_left = 0; m_hs = 0;
        m_start_prev = 0; m_start_pend = 0; m_pause_prev = 0; m_pause_pend = 0;
        exp_tick = 0; exp_drst = 0;
        step(3);
        check("reset_state", state, 0);
        check("reset_score", score, 0);
        rst = 1'b0;
        step(4);

        // Start, countdown, first ticks at level 0.
        press_start();
        step(50);

        // Four hits reach level 2, ten more saturate level at 4.
        for (int i = 0; i < 4; i++) pulse_hit();
        step(20);
        for (int i = 0; i < 10; i++) pulse_hit();
        step(10);
        check("level_sat", level, 4);

        // Restart to get level 0 again, then pause mid-period and resume.
        pulse_miss(); pulse_miss(); pulse_miss();
        step(3);
        press_start();
        step(TB_CD + 3);
        step(2);
        press_pause();
        step(20);
        press_pause();
        step(30);

        // Two misses, then simultaneous hit and terminating miss.
        pulse_hit(); pulse_hit(); pulse_hit();
        pulse_miss(); pulse_miss();
        hit = 1'b1; miss_in = 1'b1; step(1); hit = 1'b0; miss_in = 1'b0;
        check("over_state", state, 4);
        step(2);
        // Events in OVER are ignored; start clears but keeps high score.
        pulse_hit(); pulse_miss();
        press_start();
        step(TB_CD + 20);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 59) == 0) start_btn = ~start_btn;
            if ($urandom_range(0, 39) == 0) pause_btn = ~pause_btn;
            hit     = ($urandom_range(0, 3) == 0);
            miss_in = ($urandom_range(0, 24) == 0);
            step(1);
        end
        hit = 1'b0; miss_in = 1'b0; start_btn = 1'b0; pause_btn = 1'b0;
        step(4);

        // Score saturation: 270 consecutive hits do not end the round.
        rst = 1'b1; step(1); rst = 1'b0; step(2);
        press_start();
        step(TB_CD + 2);
        hit = 1'b1; step(270); hit = 1'b0; step(2);
        check("score_sat", score, 255);
        pulse_miss(); pulse_miss(); pulse_miss();
        step(3);

        // Reset in the middle of a round with score 7.
        press_start();
        step(TB_CD + 2);
        for (int i = 0; i < 7; i++) pulse_hit();
        check("score7", score, 7);
        rst = 1'b1; step(1);
        check("rst_mid_state", state, 0);
        check("rst_mid_hs", high_score, 0);
        rst = 1'b0;
        step(5);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
